// File: rtl/pump_relay_controller_mini_pkg.sv
// Shared types and constants for the pump relay controller: state encoding,
// fault codes, volume step and the registered status payload.
package pump_relay_controller_mini_pkg;

    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int unsigned VOL_W   = 16;
    localparam int unsigned STALL_W = 21;
    localparam int unsigned FC_W    = 2;

    localparam logic [VOL_W-1:0] VOL_STEP = 16'd50;

    localparam logic [FC_W-1:0] FAULT_NONE       = 2'b00;
    localparam logic [FC_W-1:0] FAULT_STALL      = 2'b01;
    localparam logic [FC_W-1:0] FAULT_BAD_TARGET = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUMPING = 2'd1,
        ST_DONE    = 2'd2,
        ST_FAULT   = 2'd3
    } pump_state_e;

    // Everything the controller reports, kept in one register.
    typedef struct packed {
        logic             relay_auto;
        logic             busy;
        logic             done;
        logic             fault;
        logic [FC_W-1:0]  fault_code;
        logic [VOL_W-1:0] delivered;
    } pump_status_t;

endpackage

// File: rtl/pump_relay_controller_mini_if.sv
// Operator/metering side of the pump relay controller: requests in, relay and status out.
interface pump_relay_controller_mini_if;
    import pump_relay_controller_mini_pkg::*;

    logic             start;
    logic             stop_req;
    logic [VOL_W-1:0] target_volume;
    logic [VOL_W-1:0] thetichdabom_mini;
    logic             relay_auto;
    logic             busy;
    logic             done;
    logic             fault;
    logic [FC_W-1:0]  fault_code;
    logic [VOL_W-1:0] delivered;

    modport master (
        output start, stop_req, target_volume, thetichdabom_mini,
        input  relay_auto, busy, done, fault, fault_code, delivered
    );

    modport slave (
        input  start, stop_req, target_volume, thetichdabom_mini,
        output relay_auto, busy, done, fault, fault_code, delivered
    );

endinterface

// File: rtl/pump_relay_controller_mini_stall_watchdog.sv
// Flags a stall when the volume count has not moved for STALL_CYCLES enabled cycles.
module pump_stall_watchdog
    import pump_relay_controller_mini_pkg::*;
#(
    parameter logic [STALL_W-1:0] STALL_CYCLES = 21'd1800000
) (
    input  logic             clk,
    input  logic             sw0,
    input  logic             enable,
    input  logic [VOL_W-1:0] value,
    output logic             stall
);

    localparam logic [STALL_W-1:0] STALL_LIM = STALL_CYCLES - 21'd1;

    logic [VOL_W-1:0]   prev_q;
    logic [STALL_W-1:0] cnt_q;
    logic [STALL_W-1:0] cnt_nxt;

    // Restart on disable or any movement of the count; saturate at the limit.
    always_comb begin
        cnt_nxt = cnt_q;
        if (!enable || (value != prev_q)) begin
            cnt_nxt = '0;
        end else if (cnt_q < STALL_LIM) begin
            cnt_nxt = cnt_q + 21'd1;
        end
    end

    // stall mirrors (cnt == STALL_CYCLES-1) but comes straight from a flop.
    always_ff @(posedge clk) begin
        if (sw0) begin
            prev_q <= '0;
            cnt_q  <= '0;
            stall  <= 1'b0;
        end else begin
            prev_q <= value;
            cnt_q  <= cnt_nxt;
            stall  <= enable && (cnt_nxt == STALL_LIM);
        end
    end

endmodule

// File: rtl/pump_relay_controller_mini.sv
// Closed-loop pump controller: energises the relay on a start edge and releases it
// when the delivered volume reaches the latched target, on operator stop or on stall.
module pump_relay_controller_mini
    import pump_relay_controller_mini_pkg::*;
#(
    parameter logic [STALL_W-1:0] STALL_CYCLES = 21'd1800000,
    parameter logic [VOL_W-1:0]   MAX_TARGET   = 16'd60000
) (
    input  logic                         clk,
    input  logic                         sw0,
    pump_relay_controller_mini_if.slave  bus
);

    pump_state_e      state_q;
    pump_state_e      state_nxt;
    logic             start_d;
    logic [VOL_W-1:0] target_lat;
    logic [VOL_W-1:0] target_nxt;
    logic [VOL_W-1:0] base_lat;
    logic [VOL_W-1:0] base_nxt;
    logic [FC_W-1:0]  code_nxt;
    logic [VOL_W-1:0] diff;
    logic             start_rise;
    logic             accept;
    logic             stall;
    pump_status_t     status_q;
    pump_status_t     status_nxt;

    assign start_rise = bus.start & ~start_d;
    assign accept     = start_rise & ~bus.stop_req;
    // Modular difference keeps delivered correct across counter wrap.
    assign diff       = bus.thetichdabom_mini - base_lat;

    pump_stall_watchdog #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .sw0    (sw0),
        .enable (status_q.busy),
        .value  (bus.thetichdabom_mini),
        .stall  (stall)
    );

    always_ff @(posedge clk) begin
        if (sw0) begin
            state_q    <= ST_IDLE;
            start_d    <= 1'b0;
            target_lat <= '0;
            base_lat   <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_nxt;
            start_d    <= bus.start;
            target_lat <= target_nxt;
            base_lat   <= base_nxt;
            status_q   <= status_nxt;
        end
    end

    // Next state, latches and registered status.
    always_comb begin
        state_nxt  = state_q;
        target_nxt = target_lat;
        base_nxt   = base_lat;
        code_nxt   = status_q.fault_code;
        status_nxt = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    base_nxt = bus.thetichdabom_mini;
                    if (bus.target_volume > MAX_TARGET) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FAULT_BAD_TARGET;
                    end else begin
                        target_nxt = bus.target_volume;
                        state_nxt  = (bus.target_volume == '0) ? ST_DONE : ST_PUMPING;
                    end
                end
            end
            ST_PUMPING: begin
                if (bus.stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (diff >= target_lat) begin
                    state_nxt = ST_DONE;
                end else if (stall) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FAULT_STALL;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        status_nxt.relay_auto = (state_nxt == ST_PUMPING);
        status_nxt.busy       = (state_nxt == ST_PUMPING);
        status_nxt.done       = (state_nxt == ST_DONE);
        status_nxt.fault      = (state_nxt == ST_FAULT);
        status_nxt.fault_code = (state_nxt == ST_FAULT) ? code_nxt : FAULT_NONE;
        status_nxt.delivered  = (state_nxt == ST_IDLE) ? '0
                              : VOL_W'(bus.thetichdabom_mini - base_nxt);
    end

    assign bus.relay_auto = status_q.relay_auto;
    assign bus.busy       = status_q.busy;
    assign bus.done       = status_q.done;
    assign bus.fault      = status_q.fault;
    assign bus.fault_code = status_q.fault_code;
    assign bus.delivered  = status_q.delivered;

endmodule

// File: tb/tb_pump_relay_controller_mini.sv
// Directed bench: pump controller closed around a behavioural volume counter
// (+VOL_STEP per metering tick while relay_auto=1, cleared by sw0).
module tb_pump_relay_controller_mini;
    import pump_relay_controller_mini_pkg::*;

    localparam logic [STALL_W-1:0] STALL_T = 21'd5000;
    localparam int unsigned        TICK    = CLK_HZ / 100_000;

    logic clk = 1'b0;
    logic sw0 = 1'b1;
    always #5 clk = ~clk;

    pump_relay_controller_mini_if bus();

    pump_relay_controller_mini #(
        .STALL_CYCLES (STALL_T),
        .MAX_TARGET   (16'd60000)
    ) dut (
        .clk (clk),
        .sw0 (sw0),
        .bus (bus)
    );

    logic [15:0] vol;
    logic [15:0] load_val = 16'd0;
    logic        load_en  = 1'b0;
    logic        tick_en  = 1'b1;
    int unsigned div;

    // Volume calculator stand-in with a shortened metering tick.
    always @(posedge clk) begin
        if (sw0) begin
            vol <= 16'd0;
            div <= 0;
        end else if (load_en) begin
            vol <= load_val;
        end else begin
            div <= (div == TICK - 1) ? 0 : div + 1;
            if (tick_en && bus.relay_auto && (div == TICK - 1)) vol <= vol + VOL_STEP;
        end
    end
    assign bus.thetichdabom_mini = vol;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic start_pulse(input logic [15:0] tv);
        bus.target_volume = tv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Runs until the relay drops; lat = negedges between target reached and release.
    task automatic run_to_release(input logic [15:0] tgt, input logic [15:0] base, output int lat);
        int reach = -1;
        logic released = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (!bus.relay_auto) begin
                lat = (reach < 0) ? -1 : i - reach;
                released = 1'b1;
                break;
            end
            if (reach < 0 && 16'(vol - base) >= tgt) reach = i;
            @(negedge clk);
        end
        if (!released) check("release_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic [15:0] base;

        bus.start = 1'b0;
        bus.stop_req = 1'b0;
        bus.target_volume = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_relay", 32'(bus.relay_auto), 32'd0);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_done",  32'(bus.done),       32'd0);
        check("rst_fault", 32'(bus.fault),      32'd0);
        check("rst_code",  32'(bus.fault_code), 32'd0);
        check("rst_deliv", 32'(bus.delivered),  32'd0);
        sw0 = 1'b0;
        repeat (2) @(negedge clk);

        // 1: target 200 from counter 0
        start_pulse(16'd200);
        check("t1_relay_on", 32'(bus.relay_auto), 32'd1);
        check("t1_busy",     32'(bus.busy),       32'd1);
        check("t1_deliv0",   32'(bus.delivered),  32'd0);
        run_to_release(16'd200, 16'd0, lat);
        check("t1_latency", 32'(lat),            32'd1);
        check("t1_done",    32'(bus.done),       32'd1);
        check("t1_deliv",   32'(bus.delivered),  32'd200);
        check("t1_vol",     32'(vol),            32'd200);
        check("t1_busy0",   32'(bus.busy),       32'd0);

        // 2: target 120 overshoots to 150, re-armed from DONE
        base = vol;
        start_pulse(16'd120);
        check("t2_done_clr", 32'(bus.done),       32'd0);
        check("t2_relay_on", 32'(bus.relay_auto), 32'd1);
        run_to_release(16'd120, base, lat);
        check("t2_latency", 32'(lat),           32'd1);
        check("t2_deliv",   32'(bus.delivered), 32'd150);
        check("t2_done",    32'(bus.done),      32'd1);

        // 2b: start held high runs once only
        base = vol;
        bus.target_volume = 16'd100;
        bus.start = 1'b1;
        @(negedge clk);
        check("t2b_relay_on", 32'(bus.relay_auto), 32'd1);
        run_to_release(16'd100, base, lat);
        check("t2b_deliv", 32'(bus.delivered), 32'd100);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(bus.relay_auto);
        end
        check("t2b_no_retrigger", 32'(n), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);

        // 3: wrap 65500 -> 14 -> 64
        load_val = 16'd65500;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        check("t3_load", 32'(vol), 32'd65500);
        start_pulse(16'd100);
        run_to_release(16'd100, 16'd65500, lat);
        check("t3_vol",   32'(vol),           32'd64);
        check("t3_deliv", 32'(bus.delivered), 32'd100);
        check("t3_done",  32'(bus.done),      32'd1);

        // 4: operator stop after two steps, then start blocked by stop
        base = vol;
        start_pulse(16'd1000);
        n = 0;
        while (16'(vol - base) < 16'd100 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_two_steps", 32'(16'(vol - base)), 32'd100);
        bus.stop_req = 1'b1;
        @(negedge clk);
        check("t4_relay", 32'(bus.relay_auto), 32'd0);
        check("t4_busy",  32'(bus.busy),       32'd0);
        check("t4_done",  32'(bus.done),       32'd0);
        check("t4_fault", 32'(bus.fault),      32'd0);
        check("t4_deliv", 32'(bus.delivered),  32'd0);
        start_pulse(16'd300);
        repeat (3) @(negedge clk);
        check("t4_blocked", 32'(bus.relay_auto), 32'd0);
        bus.stop_req = 1'b0;
        repeat (2) @(negedge clk);

        // 5: frozen counter -> stall fault after STALL_T relay cycles
        tick_en = 1'b0;
        start_pulse(16'd500);
        n = 1;
        while (bus.relay_auto && n < int'(STALL_T) + 20) begin
            @(negedge clk);
            if (bus.relay_auto) n++;
        end
        check("t5_relay_cycles", 32'(n), 32'(STALL_T));
        check("t5_fault",  32'(bus.fault),      32'd1);
        check("t5_code",   32'(bus.fault_code), 32'(FAULT_STALL));
        check("t5_relay0", 32'(bus.relay_auto), 32'd0);
        start_pulse(16'd100);
        check("t5_start_ignored", 32'(bus.relay_auto), 32'd0);
        check("t5_fault_held",    32'(bus.fault),      32'd1);
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        tick_en = 1'b1;
        check("t5_fault_clr", 32'(bus.fault),      32'd0);
        check("t5_code_clr",  32'(bus.fault_code), 32'd0);
        @(negedge clk);

        // 6: zero target, bad target, max target, sw0 mid-pump
        start_pulse(16'd0);
        check("t6_zero_done",  32'(bus.done),      32'd1);
        check("t6_zero_deliv", 32'(bus.delivered), 32'd0);
        n = int'(bus.relay_auto);
        repeat (20) begin
            @(negedge clk);
            n += int'(bus.relay_auto);
        end
        check("t6_zero_relay", 32'(n), 32'd0);
        start_pulse(16'd60001);
        check("t6_bad_fault", 32'(bus.fault),      32'd1);
        check("t6_bad_code",  32'(bus.fault_code), 32'(FAULT_BAD_TARGET));
        check("t6_bad_relay", 32'(bus.relay_auto), 32'd0);
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        @(negedge clk);
        start_pulse(16'd60000);
        check("t6_max_accept", 32'(bus.busy), 32'd1);
        repeat (25) @(negedge clk);
        check("t6_mid_pump", 32'(bus.relay_auto), 32'd1);
        sw0 = 1'b1;
        @(negedge clk);
        check("t6_sw0_relay", 32'(bus.relay_auto), 32'd0);
        check("t6_sw0_busy",  32'(bus.busy),       32'd0);
        check("t6_sw0_done",  32'(bus.done),       32'd0);
        check("t6_sw0_fault", 32'(bus.fault),      32'd0);
        check("t6_sw0_code",  32'(bus.fault_code), 32'd0);
        check("t6_sw0_deliv", 32'(bus.delivered),  32'd0);
        sw0 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
